// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequencing controller for a UART receiver.
//  - Generates the 16x oversample strobe s_tick from cfg_divisor.
//  - Gates the receiver through a small OFF/RUN/HOLD state machine.
//  - Buffers received bytes in a first-word-fall-through FIFO with a
//    valid/ready drain port.
//  - Keeps sticky overrun / frame error flags.
//  - Pulses idle_timeout when buffered data has sat untouched for a while.
// Optional feature: define UART_RX_CTRL_STATS_EN to build the 16-bit
// accepted-byte counter on rx_count; otherwise rx_count is tied to 0.
module uart_rx_ctrl #(
  parameter int DIV_W         = 16,
  parameter int FIFO_DEPTH    = 8,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          cfg_enable,
  input  logic [DIV_W-1:0]              cfg_divisor,
  output logic                          s_tick,
  output logic                          rx_enabled,
  input  logic                          rx_busy,
  input  logic                          rx_done,
  input  logic                          rx_err,
  input  logic [7:0]                    rx_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [7:0]                    m_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err,
  input  logic                          err_clr,
  output logic                          idle_timeout,
  output logic [15:0]                   rx_count,
  output logic [1:0]                    dbg_state
);

  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int CW         = AW + 1;
  // One character is 10 bits of 16 oversample ticks each.
  localparam int IDLE_LIMIT = TIMEOUT_CHARS * 160;
  localparam int IW         = $clog2(IDLE_LIMIT + 1);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // ---------------------------------------------------------------------
  // Tick generator
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             s_tick_q, s_tick_d;

  // Count clk cycles up to cfg_divisor; ">=" makes a lowered divisor wrap at once.
  always_comb begin
    tick_cnt_d = '0;
    s_tick_d   = 1'b0;
    if (cfg_enable) begin
      if (tick_cnt_q >= cfg_divisor) begin
        tick_cnt_d = '0;
        s_tick_d   = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + DIV_W'(1);
      end
    end
  end

  // Tick counter and registered strobe.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      tick_cnt_q <= '0;
      s_tick_q   <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      s_tick_q   <= s_tick_d;
    end
  end

  assign s_tick = s_tick_q;

  // ---------------------------------------------------------------------
  // FIFO
  // Drain handshake: a byte leaves the FIFO in every cycle where m_valid
  // and m_ready are both high at the clock edge; m_valid and m_data never
  // depend on m_ready, and m_data holds the head until it is accepted.
  // ---------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push_req;
  logic          push_acc;
  logic          pop;
  logic          drop;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // A byte flagged with a frame error is never buffered.
  assign push_req   = rx_done && !rx_err;
  assign pop        = !fifo_empty && m_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_acc   = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  // Pointer and occupancy update; pointers wrap naturally (depth is a power of 2).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are meaningless while empty so it has no reset.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= rx_data;
  end

  assign m_valid    = !fifo_empty;
  assign m_data     = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  // ---------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------
  logic overrun_q, overrun_d;
  logic frame_err_q, frame_err_d;

  // A new error event takes priority over a simultaneous clear.
  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (drop)         overrun_d = 1'b1;
    else if (err_clr) overrun_d = 1'b0;
    if (rx_err)       frame_err_d = 1'b1;
    else if (err_clr) frame_err_d = 1'b0;
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

  // ---------------------------------------------------------------------
  // Receiver gating FSM
  // ---------------------------------------------------------------------
  logic [1:0] state_q, state_d;

  // A frame in progress (rx_busy) is always allowed to finish before gating.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (cfg_enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!cfg_enable && !rx_busy)     state_d = ST_OFF;
        else if (fifo_full && !rx_busy) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!cfg_enable)                          state_d = ST_OFF;
        else if (count_q < CW'(FIFO_DEPTH))       state_d = ST_RUN;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstN) state_q <= ST_OFF;
    else       state_q <= state_d;
  end

  assign rx_enabled = (state_q == ST_RUN);
  assign dbg_state  = state_q;

  // ---------------------------------------------------------------------
  // Idle timeout
  // ---------------------------------------------------------------------
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          idle_fired_q, idle_fired_d;
  logic          idle_pulse_q, idle_pulse_d;

  // Count s_ticks while data waits with no new arrivals; fire once per burst.
  always_comb begin
    idle_cnt_d   = idle_cnt_q;
    idle_fired_d = idle_fired_q;
    idle_pulse_d = 1'b0;
    if (fifo_empty || push_acc) begin
      idle_cnt_d   = '0;
      idle_fired_d = 1'b0;
    end else if (s_tick_q && !idle_fired_q) begin
      if (idle_cnt_q == IW'(IDLE_LIMIT - 1)) begin
        idle_cnt_d   = '0;
        idle_fired_d = 1'b1;
        idle_pulse_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + IW'(1);
      end
    end
  end

  // Idle timer registers.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      idle_cnt_q   <= '0;
      idle_fired_q <= 1'b0;
      idle_pulse_q <= 1'b0;
    end else begin
      idle_cnt_q   <= idle_cnt_d;
      idle_fired_q <= idle_fired_d;
      idle_pulse_q <= idle_pulse_d;
    end
  end

  assign idle_timeout = idle_pulse_q;

  // ---------------------------------------------------------------------
  // Accepted-byte statistics
  // ---------------------------------------------------------------------
`ifdef UART_RX_CTRL_STATS_EN
  logic [15:0] rx_count_q, rx_count_d;

  // Count every byte that entered the FIFO; wraps at 16 bits, unaffected by err_clr.
  always_comb begin
    rx_count_d = rx_count_q;
    if (push_acc) rx_count_d = rx_count_q + 16'd1;
  end

  // Statistics register.
  always_ff @(posedge clk) begin
    if (!rstN) rx_count_q <= '0;
    else       rx_count_q <= rx_count_d;
  end

  assign rx_count = rx_count_q;
`else
  assign rx_count = 16'h0000;
`endif

endmodule
